// File: rtl/button_evt_pkg.sv
// Shared event-type codes, button FSM states and the in-button priority
// picker used by the button event scheduler.
package button_evt_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_LONG    = 2'd1;
  localparam logic [1:0] EVT_REPEAT  = 2'd2;
  localparam logic [1:0] EVT_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_LHELD = 2'd2
  } btn_state_t;

  // Pending bits are indexed by event code, so the lowest set bit is the
  // highest-priority event: PRESS > LONG > REPEAT > RELEASE.
  function automatic logic [1:0] first_type(input logic [3:0] pend);
    if (pend[EVT_PRESS])       return EVT_PRESS;
    else if (pend[EVT_LONG])   return EVT_LONG;
    else if (pend[EVT_REPEAT]) return EVT_REPEAT;
    else                       return EVT_RELEASE;
  endfunction

endpackage

// File: rtl/button_event_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from i_ptr, wrapping back to 0.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  input  logic [3:0]   i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [3:0]   o_idx,
  output logic         o_any
);

  // Two passes: ptr..N-1 first, then 0..ptr-1, so the wrap needs no modulo.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!o_any && i_req[j] && (j >= int'(i_ptr))) begin
        o_any    = 1'b1;
        o_idx    = 4'(j);
        o_gnt[j] = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_idx    = 4'(j);
        o_gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Converts debounced per-button down/up pulses into PRESS/LONG/REPEAT/RELEASE
// events and serialises them onto one registered valid/ready port.
module button_event_scheduler
  import button_evt_pkg::*;
#(
  parameter int N_BTN    = 4,
  parameter int CNT_W    = 24,
  parameter int LONG_CNT = 12_000_000,
  parameter int REP_CNT  = 3_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_down,
  input  logic [N_BTN-1:0] btn_up,
  input  logic             rep_en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [3:0]       evt_btn,
  output logic [1:0]       evt_type,
  output logic [N_BTN-1:0] ovf,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CNT - 1);

  logic [N_BTN-1:0][3:0] w_pend;
  logic [N_BTN-1:0]      w_req;
  logic [N_BTN-1:0]      w_gnt;
  logic [3:0]            w_gnt_idx;
  logic                  w_any;
  logic [3:0]            w_gnt_pend;
  logic [1:0]            w_gnt_type;
  logic                  w_load;
  logic                  w_take;
  logic [4:0]            w_ptr_inc;
  logic [3:0]            w_ptr_nxt;

  logic                  r_valid;
  logic [3:0]            r_btn;
  logic [1:0]            r_type;
  logic [3:0]            r_rr_ptr;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       w_post, w_clr, r_pend;
    logic             w_coalesce, r_ovf;

    // Button FSM next state, hold counter and event posting.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_post      = 4'b0000;
      case (r_state)
        ST_IDLE: begin
          if (btn_down[i]) begin
            w_state_nxt       = ST_HELD;
            w_cnt_nxt         = '0;
            w_post[EVT_PRESS] = 1'b1;
          end
        end
        ST_HELD: begin
          if (btn_up[i]) begin
            w_state_nxt         = ST_IDLE;
            w_cnt_nxt           = '0;
            w_post[EVT_RELEASE] = 1'b1;
          end else if (r_cnt == LONG_LAST) begin
            w_state_nxt      = ST_LHELD;
            w_cnt_nxt        = '0;
            w_post[EVT_LONG] = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_LHELD: begin
          if (btn_up[i]) begin
            w_state_nxt         = ST_IDLE;
            w_cnt_nxt           = '0;
            w_post[EVT_RELEASE] = 1'b1;
          end else if (r_cnt == REP_LAST) begin
            w_cnt_nxt          = '0;
            w_post[EVT_REPEAT] = rep_en;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // A grant clears its bit in the same edge a new post could set it; the
    // post wins and that is not an overflow.
    assign w_clr      = (w_take && w_gnt[i]) ? (4'b0001 << w_gnt_type) : 4'b0000;
    assign w_coalesce = |(w_post & r_pend & ~w_clr);

    // FSM state, counter, pending bits and sticky overflow registers.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_pend  <= 4'b0000;
        r_ovf   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_pend  <= (r_pend & ~w_clr) | w_post;
        r_ovf   <= w_coalesce | (r_ovf & ~ovf_clr);
      end
    end

    assign w_pend[i] = r_pend;
    assign w_req[i]  = |r_pend;
    assign ovf[i]    = r_ovf;
  end

  rr_arbiter #(.N(N_BTN)) u_arb (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

  // Pending bits of the granted button, selected via the one-hot grant.
  always_comb begin
    w_gnt_pend = 4'b0000;
    for (int i = 0; i < N_BTN; i++) begin
      if (w_gnt[i]) w_gnt_pend = w_gnt_pend | w_pend[i];
    end
  end

  assign w_gnt_type = first_type(w_gnt_pend);
  assign w_load     = !r_valid || evt_ready;
  assign w_take     = w_load && w_any;
  assign w_ptr_inc  = {1'b0, w_gnt_idx} + 5'd1;
  assign w_ptr_nxt  = (w_ptr_inc == 5'(N_BTN)) ? 4'd0 : w_ptr_inc[3:0];

  // Output event register and round-robin pointer; fields hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_btn    <= 4'd0;
      r_type   <= 2'd0;
      r_rr_ptr <= 4'd0;
    end else if (w_load) begin
      if (w_any) begin
        r_valid  <= 1'b1;
        r_btn    <= w_gnt_idx;
        r_type   <= w_gnt_type;
        r_rr_ptr <= w_ptr_nxt;
      end else begin
        r_valid  <= 1'b0;
      end
    end
  end

  assign evt_valid = r_valid;
  assign evt_btn   = r_btn;
  assign evt_type  = r_type;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Scoreboard bench for button_event_scheduler with short thresholds
// (LONG_CNT=8, REP_CNT=4) and four buttons.
module tb_button_event_scheduler;
  import button_evt_pkg::*;

  localparam int N_BTN = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_down = '0;
  logic [N_BTN-1:0] btn_up = '0;
  logic             rep_en = 1'b1;
  logic             evt_valid;
  logic             evt_ready = 1'b1;
  logic [3:0]       evt_btn;
  logic [1:0]       evt_type;
  logic [N_BTN-1:0] ovf;
  logic             ovf_clr = 1'b0;

  button_event_scheduler #(
    .N_BTN(N_BTN), .CNT_W(8), .LONG_CNT(8), .REP_CNT(4)
  ) dut (
    .clk(clk), .rst(rst), .btn_down(btn_down), .btn_up(btn_up),
    .rep_en(rep_en), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_btn(evt_btn), .evt_type(evt_type), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] btn;
    logic [1:0] typ;
    int         at;   // expected handshake cycle, -1 = any
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int b, input logic [1:0] t, input int at);
    exp_t e;
    e.btn = 4'(b);
    e.typ = t;
    e.at  = at;
    q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks that a
  // stalled event keeps its fields.
  logic       prev_stall = 1'b0;
  logic [3:0] prev_btn;
  logic [1:0] prev_type;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && evt_valid) begin
        check("stall_btn_stable", evt_btn, prev_btn);
        check("stall_type_stable", evt_type, prev_type);
      end
      if (evt_valid && evt_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got btn %0d type %0d, expected none (cycle %0d)",
                   evt_btn, evt_type, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("evt_btn", evt_btn, e.btn);
          check("evt_type", evt_type, e.typ);
          if (e.at >= 0) check("evt_cycle", cyc, e.at);
        end
      end
      prev_stall = evt_valid && !evt_ready;
      prev_btn   = evt_btn;
      prev_type  = evt_type;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Holds the given pulses for exactly the current cycle.
  task automatic drive(input logic [N_BTN-1:0] dn, input logic [N_BTN-1:0] up);
    btn_down = dn;
    btn_up   = up;
    tick();
    btn_down = '0;
    btn_up   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget    = 200;
    evt_ready = 1'b1;
    while (q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("queue_drained", q.size(), 0);
    idle(3);
    check("idle_valid", evt_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1;
    idle(3);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_btn", evt_btn, 4'd0);
    check("rst_type", evt_type, 2'd0);
    check("rst_ovf", ovf, 4'd0);
    rst = 1'b0;
    idle(2);

    // 1. Tap on button 1.
    t0 = cyc;
    expect_evt(1, EVT_PRESS, t0 + 2);
    expect_evt(1, EVT_RELEASE, t0 + 5);
    drive(4'b0010, 4'b0000);
    idle(2);
    drive(4'b0000, 4'b0010);
    drain();
    check("tap_ovf", ovf, 4'd0);

    // 2. Long hold on button 2 with and without repeat.
    rep_en = 1'b1;
    t0 = cyc;
    expect_evt(2, EVT_PRESS, t0 + 2);
    expect_evt(2, EVT_LONG, t0 + 10);
    expect_evt(2, EVT_REPEAT, t0 + 14);
    expect_evt(2, EVT_REPEAT, t0 + 18);
    expect_evt(2, EVT_RELEASE, t0 + 22);
    drive(4'b0100, 4'b0000);
    idle(19);
    drive(4'b0000, 4'b0100);
    drain();
    check("hold_ovf", ovf, 4'd0);

    rep_en = 1'b0;
    t0 = cyc;
    expect_evt(2, EVT_PRESS, t0 + 2);
    expect_evt(2, EVT_LONG, t0 + 10);
    expect_evt(2, EVT_RELEASE, t0 + 22);
    drive(4'b0100, 4'b0000);
    idle(19);
    drive(4'b0000, 4'b0100);
    drain();
    rep_en = 1'b1;

    // 3. Simultaneous buttons 0 and 3, starting from rr_ptr = 0.
    do_reset();
    t0 = cyc;
    expect_evt(0, EVT_PRESS, t0 + 2);
    expect_evt(3, EVT_PRESS, t0 + 3);
    expect_evt(0, EVT_RELEASE, t0 + 6);
    expect_evt(3, EVT_RELEASE, t0 + 7);
    expect_evt(0, EVT_PRESS, t0 + 10);
    expect_evt(3, EVT_PRESS, t0 + 11);
    expect_evt(0, EVT_RELEASE, t0 + 14);
    expect_evt(3, EVT_RELEASE, t0 + 15);
    drive(4'b1001, 4'b0000);
    idle(3);
    drive(4'b0000, 4'b1001);
    idle(3);
    drive(4'b1001, 4'b0000);
    idle(3);
    drive(4'b0000, 4'b1001);
    drain();

    // 4. Backpressure during a 20-cycle hold on button 1.
    do_reset();
    evt_ready = 1'b0;
    t0 = cyc;
    drive(4'b0010, 4'b0000);
    idle(19);
    drive(4'b0000, 4'b0010);
    idle(9);
    check("bp_valid_held", evt_valid, 1'b1);
    check("bp_ovf", ovf, 4'b0010);
    expect_evt(1, EVT_PRESS, t0 + 30);
    expect_evt(1, EVT_LONG, t0 + 31);
    expect_evt(1, EVT_REPEAT, t0 + 32);
    expect_evt(1, EVT_RELEASE, t0 + 33);
    evt_ready = 1'b1;
    drain();

    // 5. ovf_clr alone, then ovf_clr coinciding with a new coalesce.
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 4'd0);

    evt_ready = 1'b0;
    t0 = cyc;
    drive(4'b0100, 4'b0000);
    idle(1);
    drive(4'b0000, 4'b0100);
    drive(4'b0100, 4'b0000);
    idle(1);
    ovf_clr = 1'b1;
    drive(4'b0000, 4'b0100);
    ovf_clr = 1'b0;
    check("ovf_clr_vs_coalesce", ovf, 4'b0100);
    idle(2);
    expect_evt(2, EVT_PRESS, t0 + 8);
    expect_evt(2, EVT_PRESS, t0 + 9);
    expect_evt(2, EVT_RELEASE, t0 + 10);
    evt_ready = 1'b1;
    drain();

    // 6. Reset in LHELD with an event held and another pending.
    do_reset();
    evt_ready = 1'b0;
    drive(4'b0001, 4'b0000);
    idle(10);
    check("pre_rst_valid", evt_valid, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", evt_valid, 1'b0);
    check("mid_rst_btn", evt_btn, 4'd0);
    check("mid_rst_type", evt_type, 2'd0);
    check("mid_rst_ovf", ovf, 4'd0);
    rst = 1'b0;
    evt_ready = 1'b1;
    drive(4'b0000, 4'b0001);
    idle(5);
    check("up_after_rst_ignored", evt_valid, 1'b0);
    t0 = cyc;
    expect_evt(0, EVT_PRESS, t0 + 2);
    drive(4'b0001, 4'b0000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
